spi_tx: RTL and testbench
=========================

Name: spi_tx

Overview:
Transmit-only serial shifter (SPI-style, mode 0) for driving a write-only peripheral such as a character LCD. A parent controller presents a WIDTH-bit word with a one-cycle valid strobe. The block shifts the word out MSB first on SDA with a clock SCL derived from the system clock by PRESCALER. The busy output frames the transfer; the parent uses it directly (or inverted) as the chip-select.

Parameters:
PRESCALER, 100, system-clock cycles per SCL half-period (integer >= 1); one bit lasts 2*PRESCALER cycles.
WIDTH, 17, number of bits per transfer (integer >= 1).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
SDA  output  1  serial data, MSB first, registered.
SCL  output  1  serial clock, idle low, registered.
din  input  WIDTH  word to transmit; sampled only on the accepting cycle.
vin  input  1  valid strobe; a transfer starts when vin=1 while busy=0.
busy  output  1  high for the whole transfer, registered.

Behaviour:
- Reset (rst=1 at a clock edge): busy=0, SCL=0, SDA=0, prescale counter=0, bit counter=0, shift register=0. Reset has priority and aborts any transfer in progress immediately; no partial completion.
- Idle: busy=0, SCL=0, SDA=0.
- Accept: at the edge ending a cycle where vin=1 and busy=0:
  - load the shift register with din;
  - set busy=1, SDA=din[WIDTH-1], SCL=0;
  - clear the prescale and bit counters.
- Latency: SDA shows the MSB and busy=1 one cycle after the vin cycle.
- vin while busy=1 is ignored. The in-flight word is unaffected, and the ignored request is not queued.
- Bit timing, prescale counter runs 0..PRESCALER-1 while busy:
  - when it reaches PRESCALER-1 it wraps to 0 and SCL toggles;
  - SCL low for PRESCALER cycles, then high for PRESCALER cycles, per bit.
- SDA changes only coincident with SCL falling (or at accept), so it is stable around each SCL rising edge. The receiver samples on SCL rising.
- On each SCL high-to-low transition:
  - if bit counter < WIDTH-1: increment it, shift left, and drive the next bit (din[WIDTH-2], then down to din[0]) on SDA;
  - if bit counter = WIDTH-1: the transfer ends, with busy=0, SDA=0 and SCL left low.
- busy is high for exactly 2*PRESCALER*WIDTH cycles per transfer. SCL shows exactly WIDTH rising edges per transfer.
- Back-to-back: vin may be asserted in the first cycle busy reads 0. It is accepted, and the next transfer begins with no extra gap.
- din is don't-care outside the accepting cycle. Changing din mid-transfer has no effect.
- Counter widths: prescale counter uses clog2(PRESCALER+1) bits; bit counter uses clog2(WIDTH+1) bits. Neither overflows.
- PRESCALER=1 is legal: SCL toggles every cycle, and one bit lasts 2 cycles.

Test Plan:
- Reset idle: hold rst 3 cycles then release, no vin -> busy=0, SCL=0, SDA=0 for 50 cycles.
- Single word (PRESCALER=2, WIDTH=17), din=17'b11111000000000011 pulsed 1 cycle:
  - busy=1 the next cycle and stays high exactly 68 cycles;
  - 17 SCL rising edges;
  - bits sampled on SCL rising reproduce din MSB first;
  - then busy=0, SCL=0, SDA=0.
- vin during transfer: second vin with a different din mid-transfer -> first word completes unchanged, second word never transmitted, busy total still 68 cycles.
- Back-to-back: din=17'h1AAAA then 17'h05555, second vin in the first idle cycle -> two contiguous 68-cycle frames with correct bits each, one idle cycle between busy periods.
- Reset mid-transfer: assert rst after 5 SCL edges -> next cycle busy=0, SCL=0, SDA=0. A new vin afterwards transmits its full word correctly.
- PRESCALER=1, WIDTH=4, din=4'b1011 -> busy 8 cycles, SCL pattern 0,1,0,1,..., sampled bits 1,0,1,1.

Source files
------------

// File: rtl/spi_tx_if.sv
// Parent-side handshake for spi_tx: a word with a one-cycle valid strobe, and busy back.
// busy doubles as the chip-select framing the transfer.
interface spi_tx_if #(
   parameter int WIDTH = 17
);
   logic [WIDTH-1:0] din;
   logic             vin;
   logic             busy;

   modport master (output din, output vin, input busy);
   modport slave  (input din, input vin, output busy);
endinterface

// File: rtl/spi_tx.sv
// Transmit-only SPI mode-0 shifter: the word goes out MSB first on SDA.
// SCL idles low, and each half-period of SCL lasts PRESCALER system clocks.
module spi_tx #(
   parameter int PRESCALER = 100,
   parameter int WIDTH     = 17
) (
   input  logic     clk,
   input  logic     rst,
   output logic     SDA,
   output logic     SCL,
   spi_tx_if.slave  bus
);
   localparam int PW = $clog2(PRESCALER + 1);
   localparam int BW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_n;
   logic [PW-1:0]    pre_cnt, pre_cnt_n;
   logic [BW-1:0]    bit_cnt, bit_cnt_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic             scl_q, scl_n;

   // SDA is the shift register MSB; clearing the register at the end of a transfer leaves SDA low.
   assign SDA      = shreg[WIDTH-1];
   assign SCL      = scl_q;
   assign bus.busy = (state == SHIFT);

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_n   = state;
      pre_cnt_n = pre_cnt;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      scl_n     = scl_q;
      case (state)
         IDLE: begin
            if (bus.vin) begin
               state_n   = SHIFT;
               shreg_n   = bus.din;
               pre_cnt_n = '0;
               bit_cnt_n = '0;
               scl_n     = 1'b0;
            end
         end
         SHIFT: begin
            if (pre_cnt == PW'(PRESCALER - 1)) begin
               pre_cnt_n = '0;
               scl_n     = ~scl_q;
               // SCL is about to fall: this is the only point where SDA moves.
               if (scl_q) begin
                  shreg_n = shreg << 1;
                  if (bit_cnt == BW'(WIDTH - 1)) begin
                     state_n   = IDLE;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt + 1'b1;
                  end
               end
            end else begin
               pre_cnt_n = pre_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments only, so every register samples the pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pre_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         scl_q   <= 1'b0;
      end else begin
         state   <= state_n;
         pre_cnt <= pre_cnt_n;
         bit_cnt <= bit_cnt_n;
         shreg   <= shreg_n;
         scl_q   <= scl_n;
      end
   end
endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx: one instance at PRESCALER=2/WIDTH=17 and one at PRESCALER=1/WIDTH=4.
// All outputs are sampled on the falling clock edge.
module tb_spi_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sda_a, scl_a, sda_b, scl_b;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   spi_tx_if #(.WIDTH(17)) if_a ();
   spi_tx_if #(.WIDTH(4))  if_b ();

   spi_tx #(.PRESCALER(2), .WIDTH(17)) dut_a (
      .clk (clk),
      .rst (rst),
      .SDA (sda_a),
      .SCL (scl_a),
      .bus (if_a.slave)
   );

   spi_tx #(.PRESCALER(1), .WIDTH(4)) dut_b (
      .clk (clk),
      .rst (rst),
      .SDA (sda_b),
      .SCL (scl_b),
      .bus (if_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at the first falling edge with busy=1; returns at the first falling edge with busy=0.
   // When inj >= 0, a second request carrying inj_din is pulsed at that busy cycle.
   task automatic capture_a(output int len, output int rises, output logic [16:0] bits,
                            input int inj, input logic [16:0] inj_din);
      logic prev_scl;
      len      = 0;
      rises    = 0;
      bits     = '0;
      prev_scl = 1'b0;
      while (if_a.busy && len < 5000) begin
         if (len == inj) begin
            if_a.vin = 1'b1;
            if_a.din = inj_din;
         end else begin
            if_a.vin = 1'b0;
         end
         len++;
         if (scl_a && !prev_scl) begin
            bits = {bits[15:0], sda_a};
            rises++;
         end
         prev_scl = scl_a;
         @(negedge clk);
      end
      if_a.vin = 1'b0;
   endtask

   task automatic pulse_a(input logic [16:0] word);
      if_a.din = word;
      if_a.vin = 1'b1;
      @(negedge clk);
      if_a.vin = 1'b0;
      if_a.din = '0;
   endtask

   task automatic run_word_a(input string tag, input logic [16:0] word);
      int len, rises;
      logic [16:0] bits;
      pulse_a(word);
      check({tag, "_lat_busy"}, if_a.busy, 1'b1);
      check({tag, "_lat_sda"}, sda_a, word[16]);
      capture_a(len, rises, bits, -1, '0);
      check({tag, "_len"}, len, 68);
      check({tag, "_rises"}, rises, 17);
      check({tag, "_bits"}, bits, word);
      check({tag, "_end"}, {if_a.busy, scl_a, sda_a}, 3'b000);
   endtask

   initial begin
      int          len, rises, bad, edges;
      logic [16:0] bits;
      logic [7:0]  scl_pat;
      logic [3:0]  bits_b;
      logic        prev;

      if_a.din = '0;
      if_a.vin = 1'b0;
      if_b.din = '0;
      if_b.vin = 1'b0;

      // Reset held 3 cycles, then 50 idle cycles with no request.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ({if_a.busy, scl_a, sda_a, if_b.busy, scl_b, sda_b} !== 6'b0) bad++;
      end
      check("reset_idle", bad, 0);

      // Single word.
      run_word_a("single", 17'b11111000000000011);

      // A second request mid-transfer is ignored and never queued.
      pulse_a(17'h1C3A5);
      check("inj_lat_busy", if_a.busy, 1'b1);
      capture_a(len, rises, bits, 20, 17'h00F0F);
      check("inj_len", len, 68);
      check("inj_rises", rises, 17);
      check("inj_bits", bits, 17'h1C3A5);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (if_a.busy !== 1'b0) bad++;
         @(negedge clk);
      end
      check("inj_not_queued", bad, 0);

      // Back-to-back frames: the second request arrives in the first idle cycle.
      pulse_a(17'h1AAAA);
      capture_a(len, rises, bits, -1, '0);
      check("b2b1_len", len, 68);
      check("b2b1_bits", bits, 17'h1AAAA);
      check("b2b_gap_idle", if_a.busy, 1'b0);
      pulse_a(17'h05555);
      check("b2b2_start", if_a.busy, 1'b1);
      capture_a(len, rises, bits, -1, '0);
      check("b2b2_len", len, 68);
      check("b2b2_rises", rises, 17);
      check("b2b2_bits", bits, 17'h05555);

      // Reset after 5 SCL edges aborts the transfer at once.
      pulse_a(17'h1FFFF);
      edges = 0;
      prev  = 1'b0;
      for (int i = 0; i < 200 && edges < 5; i++) begin
         @(negedge clk);
         if (scl_a !== prev) edges++;
         prev = scl_a;
      end
      check("abort_edges", edges, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_idle", {if_a.busy, scl_a, sda_a}, 3'b000);
      @(negedge clk);
      run_word_a("after_abort", 17'h0F0F3);

      // PRESCALER=1, WIDTH=4: one bit every two cycles.
      if_b.din = 4'b1011;
      if_b.vin = 1'b1;
      @(negedge clk);
      if_b.vin = 1'b0;
      if_b.din = 4'b0000;
      len     = 0;
      scl_pat = '0;
      bits_b  = '0;
      while (if_b.busy && len < 100) begin
         if (len < 8) scl_pat = {scl_pat[6:0], scl_b};
         if (scl_b) bits_b = {bits_b[2:0], sda_b};
         len++;
         @(negedge clk);
      end
      check("p1_len", len, 8);
      check("p1_scl_pattern", scl_pat, 8'b01010101);
      check("p1_bits", bits_b, 4'b1011);
      check("p1_end", {if_b.busy, scl_b, sda_b}, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
